// File: rtl/tamagotchi_need_arbiter.sv
// Round-robin need arbiter: grants one stat at a time, emits dwell/repeat increment
// pulses and periodic decay pulses. Define DECAY_STAGGER_EN to spread the four decays evenly.
module tamagotchi_need_arbiter #(
    parameter int unsigned DWELL_TICKS    = 3,
    parameter int unsigned REPEAT_TICKS   = 6,
    parameter int unsigned COOLDOWN_TICKS = 2,
    parameter int unsigned DECAY_TICKS    = 24
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       dead,
    input  logic       test_mode,
    output logic [1:0] sel,
    output logic       grant_valid,
    output logic [3:0] inc_pulse,
    output logic [3:0] dec_pulse
);

    localparam logic [7:0] DWELL_8  = 8'(DWELL_TICKS);
    localparam logic [7:0] REPEAT_8 = 8'(REPEAT_TICKS);
    localparam logic [7:0] COOL_8   = 8'(COOLDOWN_TICKS);
    localparam logic [7:0] DECAY_8  = 8'(DECAY_TICKS);
    localparam int unsigned QTR     = DECAY_TICKS / 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic       first_q, first_d;
    logic [1:0] rr_q, rr_d;
    logic [1:0] sel_q, sel_d;
    logic       gv_q, gv_d;
    logic [3:0] inc_q, inc_d;
    logic [3:0] dec_q, dec_d;
    logic [1:0] winner_s;
    logic       inc_hit_s;
    logic [7:0] cnt_inc_s;
    logic [7:0] thr_s;
    logic       decay_en_s;
    logic [3:0] dec_raw_s;

    // Round-robin search: lowest offset from rr_q wins, so scan offsets downward.
    always_comb begin
        winner_s = rr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[rr_q + 2'(k)]) begin
                winner_s = rr_q + 2'(k);
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            dcnt_q  <= 8'd0;
            first_q <= 1'b0;
            rr_q    <= 2'd0;
            sel_q   <= 2'd0;
            gv_q    <= 1'b0;
            inc_q   <= 4'd0;
            dec_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            first_q <= first_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            gv_q    <= gv_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    // Next-state logic: grant, dwell/repeat counting and cooldown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        rr_d      = rr_q;
        sel_d     = sel_q;
        inc_hit_s = 1'b0;
        cnt_inc_s = cnt_q + 8'd1;
        thr_s     = first_q ? DWELL_8 : REPEAT_8;
        if (dead) begin
            state_d = ST_IDLE;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (req != 4'd0) begin
                        sel_d   = winner_s;
                        cnt_d   = 8'd0;
                        first_d = 1'b1;
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!req[sel_q]) begin
                        state_d = ST_COOL;
                        rr_d    = sel_q + 2'd1;
                        cnt_d   = 8'd0;
                    end else if (cnt_inc_s == thr_s) begin
                        inc_hit_s = 1'b1;
                        cnt_d     = 8'd0;
                        first_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_COOL: begin
                    if (cnt_inc_s >= COOL_8) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output logic: pulse strobes, grant flag and decay scheduling.
    always_comb begin
        gv_d       = (state_d == ST_GRANT);
        inc_d      = inc_hit_s ? (4'b0001 << sel_q) : 4'd0;
        decay_en_s = tick && !dead && !test_mode;
        dcnt_d     = dcnt_q;
        dec_raw_s  = 4'd0;
        if (decay_en_s) begin
            dcnt_d = (dcnt_q == DECAY_8 - 8'd1) ? 8'd0 : dcnt_q + 8'd1;
`ifdef DECAY_STAGGER_EN
            for (int i = 0; i < 4; i++) begin
                if (dcnt_q == 8'(i * QTR)) begin
                    dec_raw_s[i] = 1'b1;
                end else begin
                    dec_raw_s[i] = 1'b0;
                end
            end
`else
            if (dcnt_q == DECAY_8 - 8'd1) begin
                dec_raw_s = 4'b1111;
            end else begin
                dec_raw_s = 4'd0;
            end
`endif
            // Feeding and decaying the same stat never coincide.
            if (state_q == ST_GRANT) begin
                dec_raw_s[sel_q] = 1'b0;
            end else begin
                dec_raw_s = dec_raw_s;
            end
        end else begin
            dcnt_d = dcnt_q;
        end
        dec_d = dec_raw_s;
    end

    assign sel         = sel_q;
    assign grant_valid = gv_q;
    assign inc_pulse   = inc_q;
    assign dec_pulse   = dec_q;

endmodule

// File: tb/tb_tamagotchi_need_arbiter.sv
// Self-checking bench for tamagotchi_need_arbiter: table vectors, corner sequences
// and random stimulus against a tick-level behavioural model.
module tb_tamagotchi_need_arbiter;

    localparam int DW = 3;
    localparam int RP = 6;
    localparam int CD = 2;
    localparam int DK = 24;

    logic       clk = 1'b0;
    logic       btn_reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] req = 4'd0;
    logic       dead = 1'b0;
    logic       test_mode = 1'b0;
    logic [1:0] sel;
    logic       grant_valid;
    logic [3:0] inc_pulse;
    logic [3:0] dec_pulse;

    tamagotchi_need_arbiter #(
        .DWELL_TICKS(DW), .REPEAT_TICKS(RP), .COOLDOWN_TICKS(CD), .DECAY_TICKS(DK)
    ) dut (
        .clk(clk), .btn_reset(btn_reset), .tick(tick), .req(req), .dead(dead),
        .test_mode(test_mode), .sel(sel), .grant_valid(grant_valid),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit       m_grant;
    int       m_sel, m_rr, m_cool, m_held, m_dcnt;
    bit [3:0] e_inc, e_dec;
    logic [3:0] obs_inc, obs_dec;

    typedef struct {
        logic [3:0] r;
        logic [1:0] s;
        logic       gv;
        logic [3:0] inc;
    } vec_t;
    vec_t tbl[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dec_expect(input int d);
`ifdef DECAY_STAGGER_EN
        if (d % (DK / 4) == 0) return 4'b0001 << (d / (DK / 4));
        return 4'd0;
`else
        return (d == DK - 1) ? 4'b1111 : 4'd0;
`endif
    endfunction

    task automatic model_reset();
        m_grant = 0; m_sel = 0; m_rr = 0; m_cool = 0; m_held = 0; m_dcnt = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d, input logic tm);
        bit found;
        e_inc = 4'd0;
        e_dec = 4'd0;
        if (d) begin
            m_grant = 0;
            m_cool  = 0;
            return;
        end
        if (!tm) begin
            e_dec = dec_expect(m_dcnt);
            if (m_grant) e_dec[m_sel] = 1'b0;
            m_dcnt = (m_dcnt + 1) % DK;
        end
        if (m_grant) begin
            if (!r[m_sel]) begin
                m_grant = 0;
                m_cool  = (CD > 0) ? CD : 1;
                m_rr    = (m_sel + 1) % 4;
            end else begin
                m_held++;
                if (m_held == DW || (m_held > DW && (m_held - DW) % RP == 0))
                    e_inc[m_sel] = 1'b1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 4'd0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_rr + k) % 4]) begin
                    found = 1;
                    m_sel = (m_rr + k) % 4;
                end
            end
            m_grant = 1;
            m_held  = 0;
        end
    endtask

    task automatic tick_phase(input logic [3:0] r, input logic d, input logic tm);
        req = r; dead = d; test_mode = tm; tick = 1'b1;
        model_step(r, d, tm);
        @(negedge clk);
        tick = 1'b0;
        cmp("model_tick", {sel, grant_valid, inc_pulse, dec_pulse},
            {2'(m_sel), m_grant, e_inc, e_dec});
        obs_inc = inc_pulse;
        obs_dec = dec_pulse;
    endtask

    task automatic idle_phase();
        @(negedge clk);
        cmp("model_idle", {sel, grant_valid, inc_pulse, dec_pulse},
            {2'(m_sel), m_grant, 8'h00});
    endtask

    task automatic apply(input logic [3:0] r, input logic d, input logic tm);
        tick_phase(r, d, tm);
        idle_phase();
    endtask

    task automatic do_reset();
        btn_reset = 1'b0; tick = 1'b0; req = 4'd0; dead = 1'b0; test_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        btn_reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] acc;
        logic [3:0] rr_req;
        logic       r_dead, r_tm;

        // Round-robin table: each grant held 3 ticks, released, 2 cooldown ticks.
        for (int g = 0; g < 5; g++) begin
            logic [1:0] s;
            s = 2'(g);
            tbl.push_back('{4'hF, s, 1'b1, 4'h0});
            tbl.push_back('{4'hF, s, 1'b1, 4'h0});
            tbl.push_back('{4'hF, s, 1'b1, 4'h0});
            tbl.push_back('{4'hF, s, 1'b1, 4'b0001 << s});
            if (g < 4) begin
                tbl.push_back('{4'hF & ~(4'b0001 << s), s, 1'b0, 4'h0});
                tbl.push_back('{4'hF, s, 1'b0, 4'h0});
                tbl.push_back('{4'hF, s, 1'b0, 4'h0});
            end
        end

        do_reset();
        cmp("reset_state", {sel, grant_valid, inc_pulse, dec_pulse}, 11'd0);

        foreach (tbl[i]) begin
            tick_phase(tbl[i].r, 1'b0, 1'b1);
            cmp("rr_table", {sel, grant_valid, inc_pulse, dec_pulse},
                {tbl[i].s, tbl[i].gv, tbl[i].inc, 4'h0});
            idle_phase();
        end

        // Dwell and repeat on stat 2.
        do_reset();
        apply(4'b0100, 1'b0, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            tick_phase(4'b0100, 1'b0, 1'b1);
            cmp("dwell_repeat", obs_inc, (k == 3 || k == 9 || k == 15) ? 4'b0100 : 4'b0000);
            idle_phase();
        end

        // Cooldown: release stat 0 while stat 1 waits.
        do_reset();
        acc = 4'd0;
        apply(4'b0011, 1'b0, 1'b1);
        apply(4'b0011, 1'b0, 1'b1);
        tick_phase(4'b0010, 1'b0, 1'b1); acc |= obs_inc; idle_phase();
        tick_phase(4'b0010, 1'b0, 1'b1); acc |= obs_inc; idle_phase();
        tick_phase(4'b0010, 1'b0, 1'b1); acc |= obs_inc;
        cmp("cooldown_no_grant", {sel, grant_valid}, {2'd0, 1'b0});
        idle_phase();
        tick_phase(4'b0010, 1'b0, 1'b1);
        cmp("cooldown_grant1", {sel, grant_valid}, {2'd1, 1'b1});
        cmp("cooldown_no_inc0", acc, 4'd0);
        idle_phase();

        // Decay schedule, freeze, and resume from the held count.
        do_reset();
        for (int k = 0; k < 2 * DK; k++) begin
            tick_phase(4'd0, 1'b0, 1'b0);
            cmp("decay_sched", obs_dec, dec_expect(k % DK));
            idle_phase();
        end
        acc = 4'd0;
        for (int k = 0; k < 30; k++) begin
            apply(4'd0, 1'b0, 1'b1);
            acc |= obs_dec;
        end
        cmp("freeze_no_dec", acc, 4'd0);
        for (int k = 0; k < DK; k++) begin
            tick_phase(4'd0, 1'b0, 1'b0);
            cmp("decay_resume", obs_dec, dec_expect(k));
            idle_phase();
        end

        // Mask: stat 3 granted across its decay slot.
        do_reset();
        acc = 4'd0;
        for (int k = 0; k < 30; k++) begin
            apply(4'b1000, 1'b0, 1'b0);
            acc |= obs_dec;
        end
        cmp("mask_dec3", acc, 4'b0111);

        // Dead mid-grant.
        do_reset();
        apply(4'b0100, 1'b0, 1'b1);
        apply(4'b0100, 1'b0, 1'b1);
        tick_phase(4'b0100, 1'b1, 1'b0);
        cmp("dead_idle", grant_valid, 1'b0);
        idle_phase();
        acc = 4'd0;
        for (int k = 0; k < 30; k++) begin
            apply(4'b0100, 1'b1, 1'b0);
            acc |= obs_inc | obs_dec;
        end
        cmp("dead_no_pulse", acc, 4'd0);
        apply(4'b0100, 1'b0, 1'b1);
        cmp("dead_regrant", {sel, grant_valid}, {2'd2, 1'b1});

        // Async reset between ticks.
        apply(4'b0100, 1'b0, 1'b1);
        #2 btn_reset = 1'b0;
        #1 cmp("async_reset", {sel, grant_valid, inc_pulse, dec_pulse}, 11'd0);
        @(negedge clk);
        btn_reset = 1'b1;
        model_reset();

        // Random stimulus against the model.
        rr_req = 4'd0; r_dead = 1'b0; r_tm = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) rr_req[$urandom_range(0, 3)] ^= 1'b1;
            r_dead = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) r_tm = ~r_tm;
            apply(rr_req, r_dead, r_tm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
